bram_mailbox_ctrl: RTL

BRAM_MAILBOX_CTRL -- requirements
Module: bram_mailbox_ctrl

---
 rtl/bram_mailbox_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bram_mailbox_ctrl.sv
// BRAM mailbox controller. It polls a command word, streams a job's input words
// to a core, writes the core's results back to BRAM and reports BUSY/DONE in a status word.
module bram_mailbox_ctrl #(
    parameter int                WORD_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                N_IN        = 1024,
    parameter int                N_OUT       = 2048,
    parameter logic [ADDR_W-1:0] CMD_ADDR    = 'h1004,
    parameter logic [ADDR_W-1:0] STAT_ADDR   = 'h1789,
    parameter logic [ADDR_W-1:0] IN_BASE     = 'h0000,
    parameter logic [ADDR_W-1:0] OUT_BASE    = 'h1800,
    parameter logic [31:0]       START_MAGIC = 32'hdeadbeef,
    parameter logic [31:0]       CLEAR_MAGIC = 32'h00000000,
    parameter logic [31:0]       BUSY_MAGIC  = 32'hb0bacafe,
    parameter logic [31:0]       DONE_MAGIC  = 32'hd01ecafe
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [WORD_W-1:0]     bram_rdata,
    output logic                  bram_en,
    output logic [WORD_W/8-1:0]   bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [WORD_W-1:0]     bram_wdata,
    output logic                  in_valid,
    output logic [WORD_W-1:0]     in_data,
    input  logic                  in_ready,
    input  logic                  out_valid,
    input  logic [WORD_W-1:0]     out_data,
    output logic                  out_ready,
    output logic                  busy
);
    localparam int BW    = WORD_W / 8;
    localparam int N_MAX = (N_IN > N_OUT) ? N_IN : N_OUT;
    localparam int CW    = $clog2(N_MAX) + 1;
    localparam logic [WORD_W-1:0] START_W = WORD_W'(START_MAGIC);
    localparam logic [WORD_W-1:0] CLEAR_W = WORD_W'(CLEAR_MAGIC);
    localparam logic [WORD_W-1:0] BUSY_W  = WORD_W'(BUSY_MAGIC);
    localparam logic [WORD_W-1:0] DONE_W  = WORD_W'(DONE_MAGIC);
    localparam logic [CW-1:0]     LAST_IN  = CW'(N_IN - 1);
    localparam logic [CW-1:0]     LAST_OUT = CW'(N_OUT - 1);

    typedef enum logic [3:0] {
        POLL_A, POLL_D, CLR, BUSYW, RD_A, RD_D, PUSH, COLLECT, DONEW
    } state_t;

    state_t              state;
    logic [CW-1:0]       i, o, i_nxt;
    logic                en_r;
    logic [BW-1:0]       we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [WORD_W-1:0]   wdata_r;
    logic                wr_out;

    // Result writes go out in the handshake cycle itself, so they bypass the
    // registered access and are muxed straight onto the port.
    assign i_nxt      = i + CW'(1);
    assign wr_out     = (state == COLLECT) && out_valid;
    assign bram_en    = wr_out | en_r;
    assign bram_we    = wr_out ? '1 : we_r;
    assign bram_addr  = wr_out ? OUT_BASE + ADDR_W'(o) : addr_r;
    assign bram_wdata = wr_out ? out_data : wdata_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= POLL_A;
            i         <= '0;
            o         <= '0;
            en_r      <= 1'b0;
            we_r      <= '0;
            addr_r    <= '0;
            wdata_r   <= '0;
            in_valid  <= 1'b0;
            in_data   <= '0;
            out_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            en_r <= 1'b0;
            we_r <= '0;
            case (state)
                // Access registers are loaded on entry to a state; straight out of
                // reset POLL_A has not presented its read yet, so it does so first.
                POLL_A: begin
                    if (en_r) begin
                        state <= POLL_D;
                    end else begin
                        en_r   <= 1'b1;
                        addr_r <= CMD_ADDR;
                    end
                end
                POLL_D: begin
                    en_r   <= 1'b1;
                    addr_r <= CMD_ADDR;
                    if (bram_rdata == START_W) begin
                        state   <= CLR;
                        busy    <= 1'b1;
                        we_r    <= '1;
                        wdata_r <= CLEAR_W;
                    end else begin
                        state <= POLL_A;
                    end
                end
                CLR: begin
                    state   <= BUSYW;
                    i       <= '0;
                    o       <= '0;
                    en_r    <= 1'b1;
                    we_r    <= '1;
                    addr_r  <= STAT_ADDR;
                    wdata_r <= BUSY_W;
                end
                BUSYW: begin
                    state  <= RD_A;
                    en_r   <= 1'b1;
                    addr_r <= IN_BASE + ADDR_W'(i);
                end
                RD_A: state <= RD_D;
                RD_D: begin
                    state    <= PUSH;
                    in_data  <= bram_rdata;
                    in_valid <= 1'b1;
                end
                PUSH: begin
                    if (in_ready) begin
                        i        <= i_nxt;
                        in_valid <= 1'b0;
                        if (i == LAST_IN) begin
                            state     <= COLLECT;
                            out_ready <= 1'b1;
                        end else begin
                            state  <= RD_A;
                            en_r   <= 1'b1;
                            addr_r <= IN_BASE + ADDR_W'(i_nxt);
                        end
                    end
                end
                COLLECT: begin
                    if (out_valid) begin
                        o <= o + CW'(1);
                        if (o == LAST_OUT) begin
                            state     <= DONEW;
                            out_ready <= 1'b0;
                            en_r      <= 1'b1;
                            we_r      <= '1;
                            addr_r    <= STAT_ADDR;
                            wdata_r   <= DONE_W;
                        end
                    end
                end
                DONEW: begin
                    state  <= POLL_A;
                    busy   <= 1'b0;
                    en_r   <= 1'b1;
                    addr_r <= CMD_ADDR;
                end
                default: state <= POLL_A;
            endcase
        end
    end
endmodule
